rx_counter_checker: RTL and testbench
=====================================

// Module: rx_counter_checker
// PURPOSE
//  Consumes the 8-bit parallel words from the HPIO RX deserializer (data_to_fabric_*,
//  qualified by fifo_rd_data_valid) and checks them against the TX incrementing byte counter.
//  Finds the bit offset by bit-slipping, then flywheels an expected counter and counts errors.
//  Exposes status and counters to the ILA and host logic. Runs in the 200 MHz FIFO read-clock domain.
// PARAMETERS
//  MATCH_LEN  16  consecutive good compares needed in SEARCH to declare lock (>=2)
//  LOSS_LEN   4   consecutive mismatches while LOCKED that drop lock (>=1)
//  CNT_W      32  width of err_cnt and word_cnt
// PORTS
//  clk         in   1      clock (FIFO read clock, 200 MHz)
//  rst_n       in   1      asynchronous reset, active-low
//  din_valid   in   1      din is valid this cycle (fifo_rd_data_valid)
//  din         in   8      raw deserialized word, bit 0 is first-received bit
//  clr_cnt     in   1      sync pulse: clear err_cnt, word_cnt, loss_cnt
//  dout_valid  out  1      registered copy of din_valid
//  dout        out  8      bit-aligned word
//  locked      out  1      1 while FSM is in LOCKED
//  bit_offset  out  3      current alignment offset
//  err_cnt     out  CNT_W  mismatches while LOCKED, saturating
//  word_cnt    out  CNT_W  valid words compared while LOCKED, saturating
//  loss_cnt    out  16     LOCKED->SEARCH transitions, saturating
// BEHAVIOUR
//  Reset (async assert, sync release): all outputs 0; prev=0; ref=0; expected=0; match_cnt=0;
//   err_run=0; prime=1; state=SEARCH.
//  All state changes occur only on cycles with din_valid=1; invalid cycles hold everything except
//   dout_valid<=0 and clr_cnt handling.
//  Alignment: w={prev,din} (16b); aligned=w[bit_offset+:8]. Each valid cycle: prev<=din,
//   dout<=aligned, dout_valid<=1. Latency is 1 clk.
//  SEARCH:
//   prime=1: ref<=aligned, prime<=0, match_cnt<=0 (no compare).
//   aligned==ref+1 (mod 256): ref<=aligned, match_cnt++. If it reaches MATCH_LEN, then
//    state<=LOCKED, locked<=1, expected<=aligned+1, and err_run<=0.
//   mismatch: bit_offset<=bit_offset+1 (7 wraps to 0), match_cnt<=0, prime<=1.
//  LOCKED (flywheel): each valid word sets word_cnt++ and expected<=expected+1, match or not.
//   aligned==expected: err_run<=0.
//   mismatch: err_cnt++, err_run++. If err_run+1==LOSS_LEN, then state<=SEARCH, locked<=0,
//    loss_cnt++, prime<=1, match_cnt<=0. bit_offset is kept and searching restarts from it.
//  Saturation: err_cnt, word_cnt and loss_cnt hold at all-ones.
//  clr_cnt=1 zeroes all three counters that cycle and beats a simultaneous increment.
//   FSM, locked and bit_offset are unaffected.
//  Reset mid-operation returns to reset values immediately, with no clk needed.
// TESTING
//  1. din=0,1,2,... every cycle, offset 0: locked=1 on edge of 17th valid word (1 prime + 16);
//     bit_offset=0, err_cnt=0, dout=counter 1 clk after din.
//  2. Serial counter stream pre-shifted so alignment needs offset 3: locked with bit_offset=3;
//     dout follows the counter sequence; err_cnt=0.
//  3. Locked, one word corrupted (0x40 sent as 0xFF): err_cnt=1, locked stays 1, next word
//     compares good; word_cnt keeps counting every valid word.
//  4. Locked, stream shifted by 1 bit: locked drops on 4th consecutive mismatch, loss_cnt=1,
//     err_cnt=4; relock with bit_offset advanced by 1.
//  5. din_valid toggling 1/0 with counter on valid cycles only: lock as in test 1, counted in
//     valid words; no errors.
//  6. Force err_cnt to 2^CNT_W-1 and inject error: holds. clr_cnt with an error in the same cycle
//     gives err_cnt=0. rst_n low while locked clears all outputs asynchronously.

Source files
------------

// File: rtl/rx_counter_checker.sv
// rx_counter_checker
// Checks aligned deserializer words against the TX incrementing byte counter.
// The FSM first hunts for the bit offset by slipping one bit on every
// mismatch. Once it has seen MATCH_LEN consecutive increments it locks and
// flywheels an expected counter, counting errors until LOSS_LEN consecutive
// misses drop it back to SEARCH.
//
// state  | meaning
// SEARCH | hunting for bit offset; prime captures a reference, then count increments
// LOCKED | flywheel expected counter, count words/errors, drop on LOSS_LEN misses
module rx_counter_checker #(
  parameter int MATCH_LEN = 16,
  parameter int LOSS_LEN  = 4,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_valid,
  input  logic [7:0]       din,
  input  logic             clr_cnt,
  output logic             dout_valid,
  output logic [7:0]       dout,
  output logic             locked,
  output logic [2:0]       bit_offset,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] word_cnt,
  output logic [15:0]      loss_cnt
);

  localparam int MW = $clog2(MATCH_LEN + 1);
  localparam int EW = $clog2(LOSS_LEN + 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t           state, state_nx;
  logic [7:0]       prev, prev_nx;
  logic [7:0]       ref_word, ref_nx;
  logic [7:0]       expected, expected_nx;
  logic [MW-1:0]    match_cnt, match_nx;
  logic [EW-1:0]    err_run, err_run_nx;
  logic             prime, prime_nx;
  logic             dout_valid_nx;
  logic [7:0]       dout_nx;
  logic [2:0]       offset_nx;
  logic [CNT_W-1:0] err_cnt_nx, word_cnt_nx;
  logic [15:0]      loss_cnt_nx;
  logic             err_inc, word_inc, loss_inc;
  logic [15:0]      window;
  logic [7:0]       aligned;

  assign window = {prev, din};
  assign aligned = window[bit_offset +: 8];
  assign locked = (state == LOCKED);

  // State register and all datapath registers; prime starts set so the first word is captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SEARCH;
      prev       <= '0;
      ref_word   <= '0;
      expected   <= '0;
      match_cnt  <= '0;
      err_run    <= '0;
      prime      <= 1'b1;
      dout_valid <= 1'b0;
      dout       <= '0;
      bit_offset <= '0;
      err_cnt    <= '0;
      word_cnt   <= '0;
      loss_cnt   <= '0;
    end else begin
      state      <= state_nx;
      prev       <= prev_nx;
      ref_word   <= ref_nx;
      expected   <= expected_nx;
      match_cnt  <= match_nx;
      err_run    <= err_run_nx;
      prime      <= prime_nx;
      dout_valid <= dout_valid_nx;
      dout       <= dout_nx;
      bit_offset <= offset_nx;
      err_cnt    <= err_cnt_nx;
      word_cnt   <= word_cnt_nx;
      loss_cnt   <= loss_cnt_nx;
    end
  end

  // Next-state logic: everything advances only on valid words; counter clear wins over increment.
  always_comb begin
    state_nx      = state;
    prev_nx       = prev;
    ref_nx        = ref_word;
    expected_nx   = expected;
    match_nx      = match_cnt;
    err_run_nx    = err_run;
    prime_nx      = prime;
    dout_valid_nx = din_valid;
    dout_nx       = dout;
    offset_nx     = bit_offset;
    err_inc       = 1'b0;
    word_inc      = 1'b0;
    loss_inc      = 1'b0;

    if (din_valid) begin
      prev_nx = din;
      dout_nx = aligned;
      if (state == SEARCH) begin
        if (prime) begin
          ref_nx   = aligned;
          prime_nx = 1'b0;
          match_nx = '0;
        end else if (aligned == ref_word + 8'd1) begin
          ref_nx   = aligned;
          match_nx = match_cnt + MW'(1);
          if (match_cnt == MW'(MATCH_LEN - 1)) begin
            state_nx    = LOCKED;
            expected_nx = aligned + 8'd1;
            err_run_nx  = '0;
          end
        end else begin
          offset_nx = bit_offset + 3'd1;
          match_nx  = '0;
          prime_nx  = 1'b1;
        end
      end else begin
        word_inc    = 1'b1;
        expected_nx = expected + 8'd1;
        if (aligned == expected) begin
          err_run_nx = '0;
        end else begin
          err_inc    = 1'b1;
          err_run_nx = err_run + EW'(1);
          if (err_run == EW'(LOSS_LEN - 1)) begin
            state_nx = SEARCH;
            loss_inc = 1'b1;
            prime_nx = 1'b1;
            match_nx = '0;
          end
        end
      end
    end

    err_cnt_nx  = err_cnt;
    word_cnt_nx = word_cnt;
    loss_cnt_nx = loss_cnt;
    if (clr_cnt) begin
      err_cnt_nx  = '0;
      word_cnt_nx = '0;
      loss_cnt_nx = '0;
    end else begin
      if (err_inc && !(&err_cnt))
        err_cnt_nx = err_cnt + CNT_W'(1);
      if (word_inc && !(&word_cnt))
        word_cnt_nx = word_cnt + CNT_W'(1);
      if (loss_inc && !(&loss_cnt))
        loss_cnt_nx = loss_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_rx_counter_checker.sv
// Bench for rx_counter_checker: directed counter streams, scoreboard on dout.
module tb_rx_counter_checker;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             din_valid;
  logic [7:0]       din;
  logic             clr_cnt;
  logic             dout_valid;
  logic [7:0]       dout;
  logic             locked;
  logic [2:0]       bit_offset;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] word_cnt;
  logic [15:0]      loss_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  bit         chk_q[$];
  logic [7:0] exp_q[$];

  rx_counter_checker #(.MATCH_LEN(16), .LOSS_LEN(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .clr_cnt(clr_cnt),
    .dout_valid(dout_valid), .dout(dout), .locked(locked), .bit_offset(bit_offset),
    .err_cnt(err_cnt), .word_cnt(word_cnt), .loss_cnt(loss_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Word n of a serial counter stream that needs alignment offset off.
  function automatic logic [7:0] gen(input logic [7:0] c, input int off);
    logic [15:0] t;
    t = {c, c + 8'd1};
    t = t >> (8 - off);
    return t[7:0];
  endfunction

  task automatic send(input logic [7:0] d, input bit chk, input logic [7:0] e, input bit clr);
    @(negedge clk);
    din_valid = 1'b1;
    din       = d;
    clr_cnt   = clr;
    chk_q.push_back(chk);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit clr);
    @(negedge clk);
    din_valid = 1'b0;
    clr_cnt   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    chk_q.delete();
    exp_q.delete();
    din_valid = 1'b0;
    clr_cnt   = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every presented output word is matched against the head of the scoreboard.
  initial begin
    bit         c;
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (dout_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL dout_unexpected: got word %0h, expected none", dout);
        end else begin
          c = chk_q.pop_front();
          e = exp_q.pop_front();
          if (c) check("dout", dout, e);
        end
      end
    end
  end

  initial begin
    logic [7:0] v;
    logic [7:0] d;
    rst_n     = 1'b0;
    din_valid = 1'b0;
    din       = '0;
    clr_cnt   = 1'b0;
    do_reset();

    check("rst_dout_valid", dout_valid, 0);
    check("rst_dout", dout, 0);
    check("rst_locked", locked, 0);
    check("rst_bit_offset", bit_offset, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_word_cnt", word_cnt, 0);
    check("rst_loss_cnt", loss_cnt, 0);

    // Plain counter at offset 0: lock on the 17th word.
    for (int i = 0; i < 32; i++) begin
      send(8'(i), 1'b1, 8'(i), 1'b0);
      if (i == 15) check("t1_not_locked_16", locked, 0);
      if (i == 16) begin
        check("t1_locked_17", locked, 1);
        check("t1_bit_offset", bit_offset, 0);
        check("t1_word_cnt_at_lock", word_cnt, 0);
      end
    end
    check("t1_err_cnt", err_cnt, 0);
    check("t1_word_cnt", word_cnt, 15);

    // Single corrupted word while locked.
    for (int i = 32; i < 64; i++) send(8'(i), 1'b1, 8'(i), 1'b0);
    send(8'hFF, 1'b1, 8'hFF, 1'b0);
    check("t3_err_cnt_hit", err_cnt, 1);
    check("t3_locked_hold", locked, 1);
    send(8'd65, 1'b1, 8'd65, 1'b0);
    send(8'd66, 1'b1, 8'd66, 1'b0);
    check("t3_err_cnt_after", err_cnt, 1);
    check("t3_word_cnt", word_cnt, 50);

    idle(1'b1);
    check("clr_err_cnt", err_cnt, 0);
    check("clr_word_cnt", word_cnt, 0);
    check("clr_locked_kept", locked, 1);

    // Stream slips by one bit: lose lock after 4 misses, relock at offset 1.
    v = 8'd67;
    for (int m = 0; m < 25; m++) begin
      d = gen(v, 1);
      send(d, 1'b1, (m < 6) ? d : v, 1'b0);
      if (m == 2) check("t4_locked_after_3", locked, 1);
      if (m == 3) begin
        check("t4_unlock_after_4", locked, 0);
        check("t4_loss_cnt", loss_cnt, 1);
        check("t4_err_cnt", err_cnt, 4);
      end
      if (m == 5) check("t4_offset_slip", bit_offset, 1);
      if (m == 21) check("t4_not_relocked", locked, 0);
      if (m == 22) check("t4_relocked", locked, 1);
      v = v + 8'd1;
    end
    check("t4_bit_offset", bit_offset, 1);
    check("t4_err_cnt_final", err_cnt, 4);
    check("t4_word_cnt", word_cnt, 6);

    // Counter stream requiring offset 3 from reset.
    do_reset();
    v = 8'h10;
    for (int m = 0; m < 31; m++) begin
      d = gen(v, 3);
      send(d, (m < 2) || (m >= 6), (m < 2) ? d : v, 1'b0);
      if (m == 21) check("t2_not_locked", locked, 0);
      if (m == 22) begin
        check("t2_locked", locked, 1);
        check("t2_bit_offset", bit_offset, 3);
      end
      v = v + 8'd1;
    end
    check("t2_err_cnt", err_cnt, 0);
    check("t2_word_cnt", word_cnt, 8);

    // Gapped valid: lock counted in valid words only.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      send(8'(i + 100), 1'b1, 8'(i + 100), 1'b0);
      idle(1'b0);
      if (i == 0) check("t5_dout_valid_gap", dout_valid, 0);
      if (i == 15) check("t5_not_locked_16", locked, 0);
      if (i == 16) check("t5_locked_17", locked, 1);
    end
    check("t5_err_cnt", err_cnt, 0);
    check("t5_word_cnt", word_cnt, 3);

    // Saturation, clear-beats-increment, async reset.
    do_reset();
    for (int i = 0; i < 17; i++) send(8'(i), 1'b1, 8'(i), 1'b0);
    check("t6_locked", locked, 1);
    v = 8'd17;
    for (int it = 0; it < 86; it++) begin
      repeat (3) begin
        send(~v, 1'b1, ~v, 1'b0);
        v = v + 8'd1;
      end
      send(v, 1'b1, v, 1'b0);
      v = v + 8'd1;
    end
    check("t6_err_cnt_sat", err_cnt, 255);
    check("t6_word_cnt_sat", word_cnt, 255);
    check("t6_locked_kept", locked, 1);
    send(~v, 1'b1, ~v, 1'b0);
    v = v + 8'd1;
    check("t6_err_cnt_hold", err_cnt, 255);
    send(~v, 1'b1, ~v, 1'b1);
    v = v + 8'd1;
    check("t6_clr_beats_err", err_cnt, 0);
    check("t6_clr_word_cnt", word_cnt, 0);
    send(v, 1'b1, v, 1'b0);
    check("t6_err_after_clr", err_cnt, 0);
    check("t6_word_after_clr", word_cnt, 1);
    check("t6_locked_after_clr", locked, 1);
    check("t6_dout_valid_pre", dout_valid, 1);

    @(negedge clk);
    din_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_dout_valid", dout_valid, 0);
    check("async_dout", dout, 0);
    check("async_locked", locked, 0);
    check("async_word_cnt", word_cnt, 0);
    check("async_err_cnt", err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b0);
    check("final_scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
